// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM encoding, prefetch FIFO
// entry layout and the program-end marker word.
package fetch_pkg;

  localparam int unsigned FETCH_AW  = 32;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [31:0]         inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs; flush empties it in one cycle and
// the head output keeps the last delivered entry while the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  fetch_entry_t  last_q, last_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    last_d  = last_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    // Remember the departing head so the outputs hold it once empty.
    if (do_pop || (flush && (cnt_q != '0))) begin
      last_d = mem_q[rd_q];
    end
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      last_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      last_q <= last_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count      = cnt_q;
  assign head_valid = (cnt_q != '0);
  assign head       = head_valid ? mem_q[rd_q] : last_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: word-addressed memory requests, prefetch FIFO and
// redirect handling. Optional program-end halt is enabled by FETCH_HALT_EN.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          inst_valid,
  output logic [31:0]   inst,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
  output logic          halted
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, target_q, target_d;
  logic          push, pop, flush;
  logic [CW-1:0] count;
  fetch_entry_t  push_data, head;

  // AW is expected to be no wider than the FIFO's pc field.
  assign push_data = '{pc: FETCH_AW'(addr_q), inst: mem_rdata};
  assign pop       = inst_valid && inst_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    target_d = target_q;
    mem_req  = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = RUN;
        if (redirect) begin
          flush    = 1'b1;
          target_d = redirect_addr;
          addr_d   = redirect_addr;
        end
      end
      RUN: begin
        mem_req = (count < CW'(DEPTH));
        if (redirect) begin
          flush    = 1'b1;
          target_d = redirect_addr;
          // An unanswered request must be held stable until memory acks it.
          if (mem_req && !mem_ack) begin
            state_d = DRAIN;
          end else begin
            addr_d = redirect_addr;
          end
        end else if (mem_req && mem_ack) begin
          push   = 1'b1;
          addr_d = addr_q + AW'(1);
`ifdef FETCH_HALT_EN
          if (mem_rdata == HALT_WORD) begin
            state_d = HALT;
          end
`endif
        end
      end
      DRAIN: begin
        mem_req = 1'b1;
        if (redirect) begin
          flush    = 1'b1;
          target_d = redirect_addr;
        end
        if (mem_ack) begin
          state_d = RUN;
          addr_d  = redirect ? redirect_addr : target_q;
        end
      end
      HALT: begin
        if (redirect) begin
          flush    = 1'b1;
          target_d = redirect_addr;
          addr_d   = redirect_addr;
          state_d  = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      target_q <= target_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head_valid(inst_valid),
    .head      (head)
  );

  assign mem_addr = addr_q;
  assign inst     = head.inst;
  assign inst_pc  = head.pc[AW-1:0];

`ifdef FETCH_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: bench-side memory model with
// configurable ack latency and a scoreboard of expected {pc, inst} pops.
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b0;
  logic          halted;

  inst_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    int unsigned lat;
    logic [31:0] target;
    int unsigned n;
    logic [31:0] exp_last;
  } vec_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned mem_lat = 0;
  int unsigned wait_cnt = 0;
  int unsigned ack_cnt = 0;
  logic        ready_en = 1'b0;
  logic        zero_en = 1'b0;
  logic [31:0] zero_addr = 32'd3;
  logic [31:0] last_pc = '0;
  logic [31:0] ack_addr = '0;
  logic        acked = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (zero_en && (a == zero_addr)) return 32'h0;
    return a * 32'h0100_0193 + 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = word_of(pc);
    exp_q.push_back(e);
  endtask

  // One clock: memory responds, scoreboard checks the pop, then edge + 1.
  task automatic step();
    logic req_pre;
    req_pre   = mem_req;
    mem_ack   = mem_req && (wait_cnt >= mem_lat);
    mem_rdata = mem_req ? word_of(mem_addr) : 32'h0;
    acked     = mem_ack;
    ack_addr  = mem_addr;
    if (mem_ack) ack_cnt++;
    inst_ready = ready_en && (exp_q.size() > 0);
    if (inst_valid && inst_ready) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pop_pc", inst_pc, e.pc);
      chk("pop_inst", inst, e.inst);
      last_pc = inst_pc;
    end
    @(posedge clk);
    #1;
    wait_cnt = (req_pre && !mem_ack) ? wait_cnt + 1 : 0;
    mem_ack  = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic drain_exp(input int unsigned bound, input string name,
                           output int unsigned used);
    used = 0;
    while ((exp_q.size() > 0) && (used < bound)) begin
      step();
      used++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d words pending after %0d cycles, required 0",
               name, exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    rst      = 1'b0;
    mem_ack  = 1'b0;
    redirect = 1'b0;
    ready_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    wait_cnt = 0;
    ack_cnt  = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[4];
    int unsigned n;
    int unsigned n20;

    vecs[0] = '{lat: 0, target: 32'd100,        n: 5, exp_last: 32'd104};
    vecs[1] = '{lat: 1, target: 32'hFFFF_FFFE,  n: 4, exp_last: 32'd1};
    vecs[2] = '{lat: 2, target: 32'd7,          n: 3, exp_last: 32'd9};
    vecs[3] = '{lat: 0, target: 32'd50,         n: 6, exp_last: 32'd55};

    // Reset values and first-instruction latency.
    #3;
    chk_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("idle_no_req", 32'(mem_req), 32'd0);
    step();
    chk("run_first_req", 32'(mem_req), 32'd1);
    chk("valid_not_yet", 32'(inst_valid), 32'd0);
    step();
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_pc", inst_pc, 32'd0);

    // Zero-wait streaming: one instruction per cycle.
    ready_en = 1'b1;
    for (int i = 0; i < 8; i++) expect_pc(32'(i));
    drain_exp(20, "stream", n);
    chk("stream_cycles", 32'(n), 32'd8);

    // Backpressure fills the FIFO and stops requests at PC 4.
    apply_reset();
    repeat (10) step();
    chk("full_acks", 32'(ack_cnt), 32'd4);
    chk("full_no_req", 32'(mem_req), 32'd0);
    chk("full_addr", mem_addr, 32'd4);
    chk("full_head_pc", inst_pc, 32'd0);
    for (int i = 0; i < 10; i++) expect_pc(32'(i));
    ready_en = 1'b1;
    drain_exp(40, "full_resume", n);

    // Redirect while request for PC 5 is outstanding with 3-cycle latency.
    apply_reset();
    mem_lat  = 3;
    ready_en = 1'b1;
    for (int i = 0; i < 5; i++) expect_pc(32'(i));
    n = 0;
    while (!((exp_q.size() == 0) && mem_req && (mem_addr == 32'd5) &&
             (wait_cnt < mem_lat)) && (n < 80)) begin
      step();
      n++;
    end
    chk("reach_pc5_req", 32'(mem_req && (mem_addr == 32'd5)), 32'd1);
    redirect_addr = 32'd12;
    redirect      = 1'b1;
    step();
    chk("drain_flush", 32'(inst_valid), 32'd0);
    chk("drain_hold_addr", mem_addr, 32'd5);
    n = 0;
    while ((mem_addr == 32'd5) && (n < 10)) begin
      chk("drain_req_held", 32'(mem_req), 32'd1);
      step();
      n++;
    end
    chk("drain_target", mem_addr, 32'd12);
    expect_pc(32'd12);
    expect_pc(32'd13);
    drain_exp(40, "drain_resume", n);

    // Redirect coinciding with ack of PC 9 and a pop of PC 8.
    apply_reset();
    mem_lat  = 0;
    ready_en = 1'b1;
    for (int i = 0; i < 9; i++) expect_pc(32'(i));
    n = 0;
    while (!(mem_req && (mem_addr == 32'd9)) && (n < 40)) begin
      step();
      n++;
    end
    chk("pre_redir_pending", 32'(exp_q.size()), 32'd1);
    chk("pre_redir_valid", 32'(inst_valid), 32'd1);
    redirect_addr = 32'd3;
    redirect      = 1'b1;
    step();
    chk("redir_pop_once", 32'(exp_q.size()), 32'd0);
    chk("redir_acked_9", acked ? ack_addr : 32'hFFFF_FFFF, 32'd9);
    chk("redir_flush", 32'(inst_valid), 32'd0);
    chk("redir_addr", mem_addr, 32'd3);
    for (int i = 3; i < 6; i++) expect_pc(32'(i));
    drain_exp(40, "redir_resume", n);

    // Asynchronous reset mid-request with two entries buffered.
    mem_lat       = 2;
    redirect_addr = 32'd20;
    redirect      = 1'b1;
    step();
    n   = 0;
    n20 = 0;
    while ((n20 < 2) && (n < 40)) begin
      step();
      if (acked && ((ack_addr == 32'd20) || (ack_addr == 32'd21))) n20++;
      n++;
    end
    chk("mid_req", 32'(mem_req), 32'd1);
    chk("mid_addr", mem_addr, 32'd22);
    chk("mid_valid", 32'(inst_valid), 32'd1);
    chk("mid_head_pc", inst_pc, 32'd20);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    rst      = 1'b1;
    wait_cnt = 0;
    mem_lat  = 0;
    step();
    for (int i = 0; i < 3; i++) expect_pc(32'(i));
    drain_exp(40, "after_reset", n);

    // Program-end marker at PC 3.
    apply_reset();
    zero_en  = 1'b1;
    ready_en = 1'b1;
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 4; i++) expect_pc(32'(i));
    drain_exp(40, "halt_stream", n);
    repeat (3) step();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_no_req", 32'(mem_req), 32'd0);
    chk("halt_addr", mem_addr, 32'd4);
    chk("halt_empty", 32'(inst_valid), 32'd0);
    redirect_addr = 32'd0;
    redirect      = 1'b1;
    step();
    chk("unhalt_flag", 32'(halted), 32'd0);
    chk("unhalt_addr", mem_addr, 32'd0);
    chk("unhalt_req", 32'(mem_req), 32'd1);
    expect_pc(32'd0);
    expect_pc(32'd1);
    drain_exp(40, "unhalt_stream", n);
`else
    for (int i = 0; i < 6; i++) expect_pc(32'(i));
    drain_exp(40, "zero_word_stream", n);
    chk("zero_no_halt", 32'(halted), 32'd0);
`endif
    zero_en = 1'b0;

    // Table of redirect targets and memory latencies, including PC wrap.
    for (int v = 0; v < 4; v++) begin
      mem_lat       = vecs[v].lat;
      redirect_addr = vecs[v].target;
      redirect      = 1'b1;
      step();
      chk("tbl_flush", 32'(inst_valid), 32'd0);
      for (int k = 0; k < int'(vecs[v].n); k++) expect_pc(vecs[v].target + 32'(k));
      ready_en = 1'b1;
      drain_exp(200, "tbl", n);
      chk("tbl_last_pc", last_pc, vecs[v].exp_last);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Fetch stage sitting directly upstream of the decode/control unit. It drives word-addressed requests to instruction memory and buffers the returned words with their PCs in a small prefetch FIFO. It presents one instruction per cycle to the core over a valid/ready handshake. Jumps from the core redirect the fetch PC and flush stale words.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 32'd0, first fetch address after reset
AW, 32, PC/address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_req  out  1  instruction-memory request
mem_addr  out  AW  word address of request (PC+1 per instruction)
mem_ack  in  1  memory accepts request and returns mem_rdata this cycle
mem_rdata  in  32  instruction word, valid when mem_ack
redirect  in  1  jump taken; flush and refetch
redirect_addr  in  AW  jump target (word address)
inst_valid  out  1  FIFO head valid
inst  out  32  head instruction
inst_pc  out  AW  head PC
inst_ready  in  1  core consumes head
halted  out  1  fetch stopped (see Optional Feature)

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-low.
- Reset (async, immediate):
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0.
  - FIFO empty; state=IDLE.
  - Any outstanding request is abandoned; memory must tolerate this.
- States:
  - IDLE: one cycle after reset release, then RUN.
  - RUN: normal fetch.
  - DRAIN: an outstanding request is being discarded after a redirect.
  - HALT: only with the optional feature.
- Request rule:
  - mem_req = (state RUN and count<DEPTH) or state DRAIN.
  - Once asserted, mem_req and mem_addr stay stable until mem_ack. Count cannot rise without ack, so this holds by construction.
  - One request outstanding at most.
- Ack in RUN:
  - Push {mem_addr, mem_rdata}; mem_addr <= mem_addr+1 (wraps modulo 2^AW).
  - mem_ack with zero-wait memory gives one instruction per cycle.
- Latency: first mem_req in the first RUN cycle. A same-cycle ack gives inst_valid the next cycle (2 cycles after reset release).
- Pop: when inst_valid && inst_ready. Head outputs are registered FIFO head. Push and pop in the same cycle keep count unchanged.
- Full: count==DEPTH drops mem_req next cycle. An ack at count DEPTH-1 with a simultaneous pop is legal and count stays DEPTH-1.
- Empty: inst_valid=0. inst and inst_pc hold their last value, or 0 after reset.
- Redirect (sampled at edge, highest priority):
  - FIFO flushed, inst_valid=0 next cycle.
  - A same-cycle pop still counts as consumed.
  - Target register <= redirect_addr.
  - If mem_req high without mem_ack: go DRAIN; mem_addr unchanged until ack; the acked word is discarded; then mem_addr <= target, go RUN.
  - Otherwise (no request, or ack this cycle): the ack data is discarded, mem_addr <= redirect_addr, stay/go RUN.
  - A redirect during DRAIN updates the target and stays DRAIN.
- Count width: $clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.

Optional Feature:
FETCH_HALT_EN
- Defined:
  - Pushing a word equal to 32'h00000000 (the program-end marker) moves the FSM to HALT and asserts halted.
  - The zero word is still delivered.
  - In HALT, mem_req=0 while the FIFO drains.
  - redirect clears halted and resumes RUN at redirect_addr.
  - A zero word acked during DRAIN is discarded and does not halt.
- Undefined: halted tied 0; zero words are fetched as ordinary instructions.

Decomposition:
- Package fetch_pkg:
  - state encoding typedef (IDLE, RUN, DRAIN, HALT)
  - FIFO entry struct {pc[AW-1:0], inst[31:0]}
  - HALT_WORD=32'h0
- Sub-module fetch_fifo: parameterised synchronous FIFO with push, pop, flush, count, head outputs, same reset.
- FSM and PC logic stay in inst_fetch_unit.

Test Plan:
- Zero-wait memory (mem_ack=mem_req), inst_ready=1 after reset: inst_pc = 0,1,2,3… on consecutive cycles; first inst_valid 2 cycles after rst rises.
- inst_ready=0, DEPTH=4: exactly 4 acks, then mem_req=0 and mem_addr=4. Raise inst_ready: one pop per cycle, fetching resumes at 4, no duplicate or lost PC.
- 3-cycle ack latency, redirect to 12 while request for PC 5 outstanding: mem_addr stays 5 until ack; word 5 never appears; next inst_pc=12.
- Redirect to 3 in same cycle as ack of PC 9 and a pop: popped head counted once; word 9 discarded; inst_valid=0 next cycle; next inst_pc=3.
- Assert rst low mid-request with FIFO holding 2 entries: outputs immediately at reset values, count 0; after release, refetch from RESET_PC.
- FETCH_HALT_EN, words 0..2 nonzero and word 3 = 0: PCs 0–3 delivered, halted=1, no request to 4. Redirect to 0: halted=0 and refetch starts at 0.
